// File: rtl/seq_barrel_unshifter_pkg.sv
// Shared definitions for the sequential barrel unshifter: FSM state type and default width.
package barrel_pkg;

    localparam int unsigned DEFAULT_N = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_barrel_unshifter_rotate_stage.sv
// One conditional barrel stage: rotates data by 2**stage when enabled.
// dir=1 rotates left, dir=0 rotates right.
module rotate_stage #(
    parameter int unsigned N = 3
) (
    input  logic [2**N-1:0] data,
    input  logic            enable,
    input  logic [N-1:0]    stage,
    input  logic            dir,
    output logic [2**N-1:0] result
);

    localparam int unsigned W = 2**N;

    logic [N:0]     sh;
    logic [2*W-1:0] dbl;
    logic [2*W-1:0] tmp;

    assign sh  = (N+1)'(1) << stage;
    assign dbl = {data, data};

    // Shifting the doubled word makes the wrapped bits fall into the kept half.
    always_comb begin
        result = data;
        tmp    = '0;
        if (enable) begin
            if (dir) begin
                tmp    = dbl << sh;
                result = tmp[2*W-1:W];
            end else begin
                tmp    = dbl >> sh;
                result = tmp[W-1:0];
            end
        end
    end

endmodule

// File: rtl/seq_barrel_unshifter.sv
// Sequential barrel unshifter: undoes a rotation one binary stage per cycle.
// Optional macro UNSHIFT_ZERO_BYPASS_EN skips the SHIFT phase when amt is zero.
module seq_barrel_unshifter
    import barrel_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2**N-1:0] a,
    input  logic [N-1:0]    amt,
    input  logic            lr,
    output logic            busy,
    output logic            done,
    output logic [2**N-1:0] y
);

    localparam int unsigned    W      = 2**N;
    localparam logic [N-1:0]   K_LAST = N'(N - 1);

    state_t         state;
    logic [N-1:0]   k;
    logic [N-1:0]   amt_q;
    logic           lr_q;
    logic [W-1:0]   work;
    logic [W-1:0]   stage_out;

    // Undo direction is the opposite of the original: lr=1 (right applied) -> rotate left.
    rotate_stage #(.N(N)) u_stage (
        .data   (work),
        .enable (amt_q[k]),
        .stage  (k),
        .dir    (lr_q),
        .result (stage_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            k     <= '0;
            amt_q <= '0;
            lr_q  <= 1'b0;
            work  <= '0;
            y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work  <= a;
                        amt_q <= amt;
                        lr_q  <= lr;
                        k     <= '0;
`ifdef UNSHIFT_ZERO_BYPASS_EN
                        if (amt == '0) begin
                            y     <= a;
                            state <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
`else
                        state <= SHIFT;
`endif
                    end
                end
                SHIFT: begin
                    work <= stage_out;
                    k    <= k + N'(1);
                    // y is captured on entry to DONE so it is already valid while done is high.
                    if (k == K_LAST) begin
                        y     <= stage_out;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_barrel_unshifter.sv
// Self-checking bench for seq_barrel_unshifter (N=3) using a queue scoreboard of expected results.
module tb_seq_barrel_unshifter;

    localparam int unsigned N = 3;
    localparam int unsigned W = 8;
`ifdef UNSHIFT_ZERO_BYPASS_EN
    localparam int unsigned ZERO_LAT = 1;
`else
    localparam int unsigned ZERO_LAT = N + 1;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [N-1:0] amt = '0;
    logic         lr = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] y;

    int unsigned  tests = 0;
    int unsigned  failed = 0;
    logic [W-1:0] q_exp[$];

    seq_barrel_unshifter #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .amt   (amt),
        .lr    (lr),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rol(input logic [W-1:0] v, input int unsigned s);
        logic [W-1:0] r;
        r = v;
        for (int unsigned i = 0; i < s; i++) r = {r[W-2:0], r[W-1]};
        return r;
    endfunction

    function automatic logic [W-1:0] ror(input logic [W-1:0] v, input int unsigned s);
        logic [W-1:0] r;
        r = v;
        for (int unsigned i = 0; i < s; i++) r = {r[0], r[W-1:1]};
        return r;
    endfunction

    // Drives one start pulse and records the inverse rotation as the expected result.
    task automatic issue(input logic [W-1:0] ai, input logic [N-1:0] amti, input logic lri);
        @(negedge clk);
        a = ai; amt = amti; lr = lri; start = 1'b1;
        q_exp.push_back(lri ? rol(ai, amti) : ror(ai, amti));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int unsigned cyc, output logic seen);
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        seen = done;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done got=%b exp=0", done); end
        tests++; if (y !== 8'h00) begin failed++; $display("FAIL reset_y got=%h exp=00", y); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int unsigned bc;
        int unsigned dn;
        logic [W-1:0] yd;
        logic [W-1:0] e;
        issue(8'h1B, 3'd2, 1'b0);
        bc = 0; dn = 0; yd = 'x;
        while (busy && bc < 20) begin
            if (done) begin dn++; yd = y; end
            bc++;
            @(negedge clk);
        end
        e = q_exp.pop_front();
        tests++; if (bc !== N + 1) begin failed++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bc, N + 1); end
        tests++; if (dn !== 1) begin failed++; $display("FAIL basic_done_pulses got=%0d exp=1", dn); end
        tests++; if (yd !== e || e !== 8'hC6) begin failed++; $display("FAIL basic_y got=%h exp=%h", yd, e); end
    endtask

    task automatic test_vectors();
        int unsigned  cyc;
        logic         seen;
        logic [W-1:0] e;
        // 8'h63 is 8'hC6 rotated left by 7, exercising the full wrap.
        logic [W-1:0] va[2]  = '{8'hD8, 8'h63};
        logic [N-1:0] vamt[2] = '{3'd3, 3'd7};
        logic         vlr[2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            issue(va[i], vamt[i], vlr[i]);
            wait_done(cyc, seen);
            e = q_exp.pop_front();
            tests++; if (seen !== 1'b1 || y !== e) begin failed++; $display("FAIL vector%0d_y got=%h exp=%h seen=%b", i, y, e, seen); end
            tests++; if (cyc !== N + 1) begin failed++; $display("FAIL vector%0d_latency got=%0d exp=%0d", i, cyc, N + 1); end
        end
    endtask

    task automatic test_zero();
        int unsigned  cyc;
        logic         seen;
        logic [W-1:0] e;
        issue(8'hC6, 3'd0, 1'b0);
        wait_done(cyc, seen);
        e = q_exp.pop_front();
        tests++; if (seen !== 1'b1 || y !== 8'hC6) begin failed++; $display("FAIL zero_y got=%h exp=%h", y, e); end
        tests++; if (cyc !== ZERO_LAT) begin failed++; $display("FAIL zero_latency got=%0d exp=%0d", cyc, ZERO_LAT); end
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL zero_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_ignore_start();
        int unsigned  dn;
        logic [W-1:0] yd;
        logic [W-1:0] e;
        issue(8'h1B, 3'd2, 1'b0);
        dn = 0; yd = 'x;
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) begin a = 8'hFF; amt = 3'd5; lr = 1'b1; start = 1'b1; end
            if (c == 3) start = 1'b0;
            if (done) begin dn++; yd = y; end
            @(negedge clk);
        end
        e = q_exp.pop_front();
        tests++; if (dn !== 1) begin failed++; $display("FAIL ignore_done_pulses got=%0d exp=1", dn); end
        tests++; if (yd !== e) begin failed++; $display("FAIL ignore_y got=%h exp=%h", yd, e); end
    endtask

    task automatic test_reset_mid();
        int unsigned  dn;
        int unsigned  cyc;
        logic         seen;
        logic [W-1:0] e;
        issue(8'h1B, 3'd2, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q_exp.delete();
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        tests++; if (y !== 8'h00) begin failed++; $display("FAIL midreset_y got=%h exp=00", y); end
        dn = 0;
        for (int c = 0; c < N + 3; c++) begin
            if (done) dn++;
            @(negedge clk);
        end
        tests++; if (dn !== 0) begin failed++; $display("FAIL midreset_done_pulses got=%0d exp=0", dn); end
        issue(8'hD8, 3'd3, 1'b1);
        wait_done(cyc, seen);
        e = q_exp.pop_front();
        tests++; if (seen !== 1'b1 || y !== e) begin failed++; $display("FAIL midreset_recover_y got=%h exp=%h", y, e); end
    endtask

    task automatic test_exhaustive();
        int unsigned  cyc;
        int unsigned  lat;
        logic         seen;
        logic [W-1:0] e;
        logic [W-1:0] ai;
        for (int unsigned l = 0; l < 2; l++) begin
            for (int unsigned s = 0; s < W; s++) begin
                ai = (l != 0) ? ror(8'hC6, s) : rol(8'hC6, s);
                issue(ai, N'(s), l[0]);
                wait_done(cyc, seen);
                e = q_exp.pop_front();
                lat = (s == 0) ? ZERO_LAT : N + 1;
                tests++; if (seen !== 1'b1 || y !== e || e !== 8'hC6) begin failed++; $display("FAIL exh_lr%0d_amt%0d_y got=%h exp=%h", l, s, y, e); end
                tests++; if (cyc !== lat) begin failed++; $display("FAIL exh_lr%0d_amt%0d_latency got=%0d exp=%0d", l, s, cyc, lat); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned  cyc;
        logic         seen;
        logic [W-1:0] e;
        issue(8'h8D, 3'd1, 1'b0);
        wait_done(cyc, seen);
        e = q_exp.pop_front();
        tests++; if (seen !== 1'b1 || y !== e) begin failed++; $display("FAIL b2b_first_y got=%h exp=%h", y, e); end
        issue(8'h36, 3'd6, 1'b1);
        wait_done(cyc, seen);
        e = q_exp.pop_front();
        tests++; if (seen !== 1'b1 || y !== e) begin failed++; $display("FAIL b2b_second_y got=%h exp=%h", y, e); end
        tests++; if (cyc !== N + 1) begin failed++; $display("FAIL b2b_second_latency got=%0d exp=%0d", cyc, N + 1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_zero();
        test_ignore_start();
        test_reset_mid();
        test_exhaustive();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
